// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sequencer: state encoding, default
// command bytes and the status byte layout.
package acq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StReady,
        StReadout,
        StDrain,
        StStatTx,
        StStatWait
    } acq_state_e;

    localparam logic [7:0] CMD_ARM_DEF    = 8'h41;
    localparam logic [7:0] CMD_READ_DEF   = 8'h52;
    localparam logic [7:0] CMD_STATUS_DEF = 8'h53;
    localparam logic [7:0] CMD_ABORT_DEF  = 8'h58;

    localparam logic [3:0] STAT_NIBBLE    = 4'hA;
    localparam int         STAT_BIT_VALID = 3;
    localparam int         STAT_BIT_ARMED = 2;
    localparam int         STAT_BIT_TO    = 1;
    localparam int         STAT_BIT_ERR   = 0;

    function automatic logic [7:0] status_byte(input logic valid, input logic armed,
                                               input logic to, input logic err);
        logic [7:0] b;
        b                 = {STAT_NIBBLE, 4'b0000};
        b[STAT_BIT_VALID] = valid;
        b[STAT_BIT_ARMED] = armed;
        b[STAT_BIT_TO]    = to;
        b[STAT_BIT_ERR]   = err;
        return b;
    endfunction

endpackage

// File: rtl/tx_mux2.sv
// UART transmit source mux: readout passthrough or the sequencer's own byte/start.
// The select comes straight from a register in the sequencer, so the output never glitches on it.
module tx_mux2 (
    input  logic       i_sel_rd,
    input  logic [7:0] i_rd_data,
    input  logic       i_rd_start,
    input  logic [7:0] i_st_data,
    input  logic       i_st_start,
    output logic [7:0] o_data,
    output logic       o_start
);

    always_comb begin
        o_data  = i_st_data;
        o_start = i_st_start;
        if (i_sel_rd) begin
            o_data  = i_rd_data;
            o_start = i_rd_start;
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// Command-driven acquisition controller: arms capture, runs readout and sends a status
// byte, sharing the single UART transmitter with the readout engine.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int unsigned ARM_TIMEOUT = 50_000_000,
    parameter logic [7:0]  CMD_ARM     = CMD_ARM_DEF,
    parameter logic [7:0]  CMD_READ    = CMD_READ_DEF,
    parameter logic [7:0]  CMD_STATUS  = CMD_STATUS_DEF,
    parameter logic [7:0]  CMD_ABORT   = CMD_ABORT_DEF
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       cap_arm,
    input  logic       cap_done,
    output logic       rd_activate,
    input  logic       rd_done,
    input  logic [7:0] rd_tx_data,
    input  logic       rd_tx_start,
    input  logic       tx_active,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy
);

    localparam int unsigned CW = (ARM_TIMEOUT > 0) ? $clog2(ARM_TIMEOUT + 1) : 1;

    acq_state_e r_state;
    acq_state_e r_ret;
    logic [CW-1:0] r_cnt;
    logic       r_cap_valid;
    logic       r_to_flag;
    logic       r_err_flag;
    logic       r_done_pend;
    logic       r_stat_start;
    logic       r_rd_sel;
    logic [7:0] r_tx_hold;
    logic       r_cap_arm;
    logic       r_rd_activate;
    logic       r_busy;

    logic       w_timeout;
    logic       w_in_xfer;
    logic [7:0] w_stat_byte;

    // With ARM_TIMEOUT=0 this is constant 0 and the counter is optimised away.
    assign w_timeout   = (ARM_TIMEOUT != 0) && (r_cnt == CW'(ARM_TIMEOUT - 1));
    assign w_in_xfer   = r_state inside {StReadout, StDrain, StStatTx, StStatWait};
    assign w_stat_byte = status_byte(r_cap_valid, r_state == StArmed, r_to_flag, r_err_flag);

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_ret         <= StIdle;
            r_cnt         <= '0;
            r_cap_valid   <= 1'b0;
            r_to_flag     <= 1'b0;
            r_err_flag    <= 1'b0;
            r_done_pend   <= 1'b0;
            r_stat_start  <= 1'b0;
            r_rd_sel      <= 1'b0;
            r_tx_hold     <= 8'h00;
            r_cap_arm     <= 1'b0;
            r_rd_activate <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_ARM) begin
                            r_state   <= StArmed;
                            r_cnt     <= '0;
                            r_cap_arm <= 1'b1;
                            r_busy    <= 1'b1;
                        end else if (rx_data == CMD_STATUS) begin
                            r_state      <= StStatTx;
                            r_ret        <= StIdle;
                            r_tx_hold    <= w_stat_byte;
                            r_stat_start <= 1'b1;
                            r_busy       <= 1'b1;
                        end else begin
                            r_err_flag <= 1'b1;
                        end
                    end
                end
                StArmed: begin
                    if (cap_done || r_done_pend) begin
                        r_state     <= StReady;
                        r_cap_valid <= 1'b1;
                        r_done_pend <= 1'b0;
                        r_cnt       <= '0;
                        r_cap_arm   <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (w_timeout) begin
                        r_state   <= StIdle;
                        r_to_flag <= 1'b1;
                        r_cnt     <= '0;
                        r_cap_arm <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (rx_valid && rx_data == CMD_ABORT) begin
                        r_state   <= StIdle;
                        r_cnt     <= '0;
                        r_cap_arm <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (rx_valid && rx_data == CMD_STATUS) begin
                        r_state      <= StStatTx;
                        r_ret        <= StArmed;
                        r_tx_hold    <= w_stat_byte;
                        r_stat_start <= 1'b1;
                    end else begin
                        if (ARM_TIMEOUT != 0) r_cnt <= r_cnt + 1'b1;
                        if (rx_valid && rx_data != CMD_ARM) r_err_flag <= 1'b1;
                    end
                end
                StReady: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_READ) begin
                            r_state       <= StReadout;
                            r_rd_sel      <= 1'b1;
                            r_rd_activate <= 1'b1;
                            r_busy        <= 1'b1;
                        end else if (rx_data == CMD_ARM) begin
                            r_state     <= StArmed;
                            r_cap_valid <= 1'b0;
                            r_cnt       <= '0;
                            r_cap_arm   <= 1'b1;
                            r_busy      <= 1'b1;
                        end else if (rx_data == CMD_STATUS) begin
                            r_state      <= StStatTx;
                            r_ret        <= StReady;
                            r_tx_hold    <= w_stat_byte;
                            r_stat_start <= 1'b1;
                            r_busy       <= 1'b1;
                        end else if (rx_data == CMD_ABORT) begin
                            r_state     <= StIdle;
                            r_cap_valid <= 1'b0;
                        end else begin
                            r_err_flag <= 1'b1;
                        end
                    end
                end
                StReadout: begin
                    r_tx_hold <= rd_tx_data;
                    if (rd_done) begin
                        r_state       <= StDrain;
                        r_rd_activate <= 1'b0;
                    end
                end
                StDrain: begin
                    r_tx_hold <= rd_tx_data;
                    if (!rd_done && !tx_active) begin
                        r_state     <= StIdle;
                        r_rd_sel    <= 1'b0;
                        r_cap_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                StStatTx: begin
                    if (tx_active) begin
                        r_state      <= StStatWait;
                        r_stat_start <= 1'b0;
                    end
                end
                StStatWait: begin
                    if (!tx_active) begin
                        r_state    <= r_ret;
                        r_to_flag  <= 1'b0;
                        r_err_flag <= 1'b0;
                        r_busy     <= (r_ret == StArmed);
                    end
                end
                default: r_state <= StIdle;
            endcase

            // Placed after the case so a same-cycle set overrides the read-to-clear.
            if (rx_valid && w_in_xfer) r_err_flag <= 1'b1;
            if (cap_done && r_ret == StArmed && r_state inside {StStatTx, StStatWait}) begin
                r_done_pend <= 1'b1;
            end
        end
    end

    tx_mux2 u_tx_mux2 (
        .i_sel_rd  (r_rd_sel),
        .i_rd_data (rd_tx_data),
        .i_rd_start(rd_tx_start),
        .i_st_data (r_tx_hold),
        .i_st_start(r_stat_start),
        .o_data    (tx_data),
        .o_start   (tx_start)
    );

    assign cap_arm     = r_cap_arm;
    assign rd_activate = r_rd_activate;
    assign busy        = r_busy;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer with ARM_TIMEOUT=100; every expected value is hand-computed.
module tb_acq_sequencer;

    logic       clk_50mhz = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cap_arm;
    logic       cap_done;
    logic       rd_activate;
    logic       rd_done;
    logic [7:0] rd_tx_data;
    logic       rd_tx_start;
    logic       tx_active;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_50mhz = ~clk_50mhz;

    acq_sequencer #(
        .ARM_TIMEOUT(100)
    ) dut (
        .clk_50mhz  (clk_50mhz),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cap_arm    (cap_arm),
        .cap_done   (cap_done),
        .rd_activate(rd_activate),
        .rd_done    (rd_done),
        .rd_tx_data (rd_tx_data),
        .rd_tx_start(rd_tx_start),
        .tx_active  (tx_active),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Status request with a complete tx_start / tx_active handshake.
    task automatic do_status(input string tag, input logic [7:0] exp);
        send_cmd(8'h53);
        chk1({tag, "_start"}, tx_start, 1'b1);
        chk8({tag, "_byte"}, tx_data, exp);
        chk1({tag, "_busy"}, busy, 1'b1);
        tx_active = 1'b1;
        tick();
        chk1({tag, "_start_drop"}, tx_start, 1'b0);
        tx_active = 1'b0;
        tick();
    endtask

    initial begin
        reset       = 1'b0;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        cap_done    = 1'b0;
        rd_done     = 1'b0;
        rd_tx_data  = 8'h00;
        rd_tx_start = 1'b0;
        tx_active   = 1'b0;
        #12;
        chk1("rst_cap_arm", cap_arm, 1'b0);
        chk1("rst_rd_act", rd_activate, 1'b0);
        chk1("rst_tx_start", tx_start, 1'b0);
        chk8("rst_tx_data", tx_data, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        reset = 1'b1;
        tick();

        // Arm, then capture completes 10 cycles later.
        send_cmd(8'h41);
        chk1("arm_cap_arm", cap_arm, 1'b1);
        chk1("arm_busy", busy, 1'b1);
        repeat (9) tick();
        chk1("arm_hold", cap_arm, 1'b1);
        cap_done = 1'b1;
        tick();
        cap_done = 1'b0;
        chk1("ready_cap_arm", cap_arm, 1'b0);
        chk1("ready_busy", busy, 1'b0);
        do_status("st_ready", 8'hA8);
        chk1("st_ready_ret_busy", busy, 1'b0);

        // Readout with passthrough, an ignored abort, drain and hold of the last byte.
        send_cmd(8'h52);
        chk1("rd_act", rd_activate, 1'b1);
        chk1("rd_busy", busy, 1'b1);
        chk1("rd_start_idle", tx_start, 1'b0);
        rd_tx_data  = 8'h3C;
        rd_tx_start = 1'b1;
        #1;
        chk1("rd_pass_start", tx_start, 1'b1);
        chk8("rd_pass_data", tx_data, 8'h3C);
        send_cmd(8'h58);
        chk1("rd_abort_ignored", rd_activate, 1'b1);
        chk1("rd_abort_busy", busy, 1'b1);
        rd_tx_start = 1'b0;
        tx_active   = 1'b1;
        rd_done     = 1'b1;
        tick();
        chk1("drain_rd_act", rd_activate, 1'b0);
        chk1("drain_busy", busy, 1'b1);
        rd_done = 1'b0;
        tick();
        chk1("drain_wait_tx", busy, 1'b1);
        tx_active = 1'b0;
        tick();
        chk1("drain_done_busy", busy, 1'b0);
        chk1("drain_done_start", tx_start, 1'b0);
        chk8("drain_hold_data", tx_data, 8'h3C);
        do_status("st_after_rd", 8'hA1);
        do_status("st_cleared", 8'hA0);

        // Status while armed; cap_done during STAT_TX goes through done_pend.
        send_cmd(8'h41);
        chk1("arm2_cap_arm", cap_arm, 1'b1);
        send_cmd(8'h53);
        chk8("st_armed_byte", tx_data, 8'hA4);
        chk1("st_armed_start", tx_start, 1'b1);
        chk1("st_armed_cap_arm", cap_arm, 1'b1);
        cap_done = 1'b1;
        tick();
        cap_done = 1'b0;
        chk1("st_armed_start_hold", tx_start, 1'b1);
        chk8("st_armed_byte_hold", tx_data, 8'hA4);
        tx_active = 1'b1;
        tick();
        chk1("st_armed_start_drop", tx_start, 1'b0);
        chk1("st_armed_wait_arm", cap_arm, 1'b1);
        tx_active = 1'b0;
        tick();
        chk1("st_armed_back_arm", cap_arm, 1'b1);
        chk1("st_armed_back_busy", busy, 1'b1);
        tick();
        chk1("pend_ready_arm", cap_arm, 1'b0);
        chk1("pend_ready_busy", busy, 1'b0);
        do_status("st_pend_ready", 8'hA8);
        send_cmd(8'h58);
        do_status("st_after_abort", 8'hA0);

        // Timeout: IDLE exactly 100 cycles after entering ARMED.
        send_cmd(8'h41);
        chk1("to_armed", cap_arm, 1'b1);
        repeat (99) tick();
        chk1("to_cycle99", cap_arm, 1'b1);
        tick();
        chk1("to_cycle100_arm", cap_arm, 1'b0);
        chk1("to_cycle100_busy", busy, 1'b0);
        send_cmd(8'h52);
        chk1("idle_read_busy", busy, 1'b0);
        do_status("st_to_err", 8'hA3);
        do_status("st_to_cleared", 8'hA0);

        // Asynchronous reset in the middle of a readout.
        send_cmd(8'h41);
        cap_done = 1'b1;
        tick();
        cap_done = 1'b0;
        send_cmd(8'h52);
        rd_tx_start = 1'b1;
        #1;
        chk1("ar_pre_start", tx_start, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk1("ar_rd_act", rd_activate, 1'b0);
        chk1("ar_tx_start", tx_start, 1'b0);
        chk1("ar_cap_arm", cap_arm, 1'b0);
        chk1("ar_busy", busy, 1'b0);
        rd_tx_start = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        chk1("ar_post_busy", busy, 1'b0);
        do_status("st_post_reset", 8'hA0);
        send_cmd(8'h41);
        chk1("ar_rearm", cap_arm, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Command-driven acquisition controller between the UART receiver, the capture block, the sample readout engine and the single UART transmitter.
- Decodes one-byte host commands.
- Arms capture and detects capture completion, with an optional timeout.
- Launches and retires readout through an activate/done handshake.
- Arbitrates the UART transmitter between readout traffic and its own status byte.

Parameters:
ARM_TIMEOUT, 50_000_000, clk_50mhz cycles allowed in ARMED before auto-disarm; 0 disables the timeout.
CMD_ARM, 8'h41, arm capture command ('A').
CMD_READ, 8'h52, start readout command ('R').
CMD_STATUS, 8'h53, send status byte command ('S').
CMD_ABORT, 8'h58, disarm command ('X').

Ports:
clk_50mhz  in  1  system clock, single clock domain.
reset  in  1  asynchronous, active-low reset.
rx_data  in  8  received byte.
rx_valid  in  1  one-cycle strobe qualifying rx_data.
cap_arm  out  1  level; high while capture is armed.
cap_done  in  1  level from capture block; buffer full.
rd_activate  out  1  level to readout engine.
rd_done  in  1  readout engine finished.
rd_tx_data  in  8  readout byte.
rd_tx_start  in  1  readout transmit request.
tx_active  in  1  UART transmitter busy.
tx_data  out  8  to UART.
tx_start  out  1  to UART.
busy  out  1  high in every state except IDLE and READY.

Behaviour:
- Reset asserted (reset low), asynchronous:
  - All outputs go to 0 and state goes to IDLE.
  - Sticky flags, done_pend, the timeout counter and the return state are cleared.
  - Applies mid-readout too: rd_activate and tx_start drop immediately, with no drain.
- Command latency: rx_valid in cycle N changes state and outputs at edge N+1.
- States and transitions:
  - IDLE:
    - CMD_ARM -> ARMED.
    - CMD_STATUS -> STAT_TX, return state IDLE.
    - CMD_READ, CMD_ABORT or any unknown byte -> set err_flag, stay.
  - ARMED:
    - cap_arm=1, timeout counter increments each cycle.
    - cap_done=1 (or done_pend set) -> READY, cap_arm=0, counter cleared.
    - Counter reaching ARM_TIMEOUT-1 with no cap_done -> IDLE, set to_flag.
    - If cap_done and timeout occur in the same cycle, cap_done wins.
    - CMD_ABORT -> IDLE.
    - CMD_STATUS -> STAT_TX, return state ARMED; cap_arm stays 1 and the counter holds.
    - CMD_ARM is ignored; other bytes set err_flag.
  - READY:
    - cap_valid=1.
    - CMD_READ -> READOUT.
    - CMD_ARM -> ARMED, clears cap_valid.
    - CMD_STATUS -> STAT_TX, return state READY.
    - CMD_ABORT -> IDLE, clears cap_valid.
    - Unknown bytes set err_flag.
  - READOUT:
    - rd_activate=1.
    - tx_data/tx_start are a combinational passthrough of rd_tx_data/rd_tx_start.
    - rd_done=1 -> DRAIN.
  - DRAIN:
    - rd_activate=0, passthrough continues.
    - When rd_done=0 and tx_active=0 -> IDLE, cap_valid cleared (a capture is read once).
  - STAT_TX:
    - tx_data = status byte, registered on entry and stable throughout.
    - tx_start=1 until tx_active is sampled high -> STAT_WAIT.
  - STAT_WAIT:
    - tx_start=0.
    - tx_active=0 -> return state.
    - Clear to_flag and err_flag on this transition (read-to-clear).
- Status byte fields:
  - [7:4] = 4'hA (constant).
  - [3] = cap_valid.
  - [2] = armed, i.e. return state is ARMED.
  - [1] = to_flag.
  - [0] = err_flag.
- Outside READOUT, DRAIN and STAT_*: tx_start=0 and tx_data holds its last value.
- Any rx_valid during READOUT, DRAIN or STAT_* sets err_flag, including CMD_ABORT; the byte is otherwise discarded.
- cap_done going high during STAT_* with return state ARMED latches done_pend. On return to ARMED this causes the READY transition one cycle later.
- Timeout counter width is $clog2(ARM_TIMEOUT+1). When ARM_TIMEOUT=0 the counter logic is removed and ARMED never times out.
- A flag set and a flag clear in the same cycle: set wins.

Decomposition:
- Package acq_pkg holds:
  - the state enum typedef;
  - CMD_* defaults;
  - the status nibble constant 4'hA;
  - status bit index constants.
- One natural sub-module, tx_mux2: the registered-select 8-bit data + start mux between readout and status sources.

Test Plan:
- Arm then capture: reset, send 8'h41, raise cap_done after 10 cycles -> cap_arm=1 at N+1; cap_arm=0 and READY one cycle after cap_done; busy=0.
- Status while armed: send 8'h41 then 8'h53, pulse cap_done during STAT_TX -> tx_data=8'hA4, one tx_start handshake, cap_arm held 1; after STAT_WAIT, READY within 2 cycles (done_pend path).
- Readout: in READY send 8'h52 -> rd_activate=1; drive rd_tx_start/rd_tx_data=8'h3C -> tx_start/tx_data mirror the same cycle; rd_done -> rd_activate=0; IDLE after tx_active falls; next 'S' returns 8'hA0.
- Timeout and error: ARM_TIMEOUT=100, send 'A', no cap_done -> IDLE exactly 100 cycles after entry. Then send 8'h52, then 'S' -> tx_data=8'hA3. A second 'S' returns 8'hA0.
- Ignored traffic: during READOUT send 8'h58 -> rd_activate stays 1, no state change; a later status shows bit0=1.
- Async reset mid-readout: drop reset while tx_start=1 -> rd_activate, tx_start, cap_arm and busy are 0 before the next clock edge; state is IDLE after release.
